// File: rtl/aes_core_scheduler.sv
// Round-robin scheduler sharing one AES encrypt core between NUM_REQ requesters,
// with a watchdog that aborts operations whose core never signals completion.
module aes_core_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*128-1:0]   req_plaintext,
  input  logic [NUM_REQ*128-1:0]   req_key,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [127:0]             resp_data,
  output logic [ID_W-1:0]          resp_id,
  output logic                     resp_err,
  output logic                     core_rst,
  output logic                     core_start,
  output logic [127:0]             core_plaintext,
  output logic [127:0]             core_key,
  input  logic [127:0]             core_ciphertext,
  input  logic                     core_done
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_ABORT  = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [127:0]    pt_q, pt_d;
  logic [127:0]    key_q, key_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [127:0]    data_q, data_d;
  logic            err_q, err_d;
  logic            resp_valid_q;
  logic            core_start_q;
  logic            core_rst_q;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] grant_next;
  logic [127:0]    pt_sel;
  logic [127:0]    key_sel;

  // Round-robin search: indices at/after rr_ptr_q first, then the wrapped ones.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (ID_W'(i) >= rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end else begin
        grant_found = grant_found;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (ID_W'(i) < rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end else begin
        grant_found = grant_found;
      end
    end
  end

  // Operand mux for the winning requester and the pointer that follows it.
  always_comb begin
    pt_sel  = '0;
    key_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        pt_sel  = req_plaintext[i*128 +: 128];
        key_sel = req_key[i*128 +: 128];
      end else begin
        pt_sel  = pt_sel;
      end
    end
    if (grant_idx == ID_W'(NUM_REQ - 1)) begin
      grant_next = '0;
    end else begin
      grant_next = grant_idx + ID_W'(1);
    end
  end

  // Grant is combinational and only ever offered while idle.
  always_comb begin
    req_ready = '0;
    if ((state_q == S_IDLE) && grant_found) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (grant_idx == ID_W'(i));
      end
    end else begin
      req_ready = '0;
    end
  end

  // Next-state and datapath update for the operation sequencer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    wd_d     = wd_q;
    pt_d     = pt_q;
    key_d    = key_q;
    id_d     = id_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d  = S_LAUNCH;
          rr_ptr_d = grant_next;
          pt_d     = pt_sel;
          key_d    = key_sel;
          id_d     = grant_idx;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done still high from the previous op is ignored on the first WAIT cycle.
        if (core_done && (wd_q != '0)) begin
          data_d  = core_ciphertext;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_ABORT: begin
        data_d  = '0;
        err_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand and response registers; control strobes decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      wd_q         <= '0;
      pt_q         <= '0;
      key_q        <= '0;
      id_q         <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      core_start_q <= 1'b0;
      core_rst_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      wd_q         <= wd_d;
      pt_q         <= pt_d;
      key_q        <= key_d;
      id_q         <= id_d;
      data_q       <= data_d;
      err_q        <= err_d;
      resp_valid_q <= (state_d == S_RESP);
      core_start_q <= (state_d == S_LAUNCH);
      core_rst_q   <= (state_d == S_ABORT);
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_data      = data_q;
  assign resp_id        = id_q;
  assign resp_err       = err_q;
  assign core_start     = core_start_q;
  assign core_rst       = core_rst_q;
  assign core_plaintext = pt_q;
  assign core_key       = key_q;

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Bench for aes_core_scheduler: stub AES core, directed vector table and sequences,
// and a randomized phase checked against a cycle-level transaction model.
module tb_aes_core_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 32;
  localparam int LAT     = 13;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_plaintext;
  logic [NUM_REQ*128-1:0] req_key;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [127:0]           resp_data;
  logic [ID_W-1:0]        resp_id;
  logic                   resp_err;
  logic                   core_rst;
  logic                   core_start;
  logic [127:0]           core_plaintext;
  logic [127:0]           core_key;
  logic [127:0]           core_ciphertext;
  logic                   core_done;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rst_pulses = 0;

  always #5 clk = ~clk;

  aes_core_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_plaintext(req_plaintext), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err),
    .core_rst(core_rst), .core_start(core_start),
    .core_plaintext(core_plaintext), .core_key(core_key),
    .core_ciphertext(core_ciphertext), .core_done(core_done)
  );

  // Stand-in cipher: the FIPS-197 vector is answered exactly, anything else maps uniquely.
  function automatic logic [127:0] fake_aes(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_0f0f_c3c3_9696_a5a5_f0f0_3c3c_6969;
  endfunction

  // Stub core: done rises 11 cycles after the start cycle and is held until next start.
  logic         stub_busy, stub_done, stub_hang, stale_force;
  logic [4:0]   stub_cnt;
  logic [127:0] stub_ct;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || core_rst) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 5'd0;
      stub_done <= 1'b0;
    end else if (core_start) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 5'd1;
      stub_done <= 1'b0;
      stub_ct   <= fake_aes(core_plaintext, core_key);
    end else if (stub_busy) begin
      if (stub_cnt == 5'd10) begin
        stub_busy <= 1'b0;
        stub_done <= !stub_hang;
      end else begin
        stub_cnt <= stub_cnt + 5'd1;
      end
    end
  end
  assign core_ciphertext = stub_ct;
  assign core_done       = stub_done | stale_force;

  always @(negedge clk) begin
    if (core_rst) rst_pulses++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // req_ready must never have more than one bit set.
  always @(negedge clk) begin
    if (!rst) chk("ready_onehot", 128'($countones(req_ready) <= 1), 128'(1));
  end

  task automatic set_req(input int i, input logic [127:0] pt, input logic [127:0] key);
    req_plaintext[i*128 +: 128] = pt;
    req_key[i*128 +: 128]       = key;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_grant(output int gcyc);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
    end
    gcyc = cyc;
    if (!ok) chk("grant_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_resp(input int gcyc, output int lat);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    lat = ok ? (cyc - gcyc) : -1;
  endtask

  task automatic run_op(input string tag, input int idx, input logic [127:0] pt,
                        input logic [127:0] key, input logic [127:0] exp_data,
                        input logic exp_err, input int exp_lat, input logic stale);
    int g, lat;
    logic [NUM_REQ-1:0] onehot;
    onehot = '0;
    onehot[idx] = 1'b1;
    @(posedge clk); #1;
    set_req(idx, pt, key);
    req_valid = onehot;
    resp_ready = 1'b1;
    stale_force = stale;
    wait_grant(g);
    chk({tag, "_grant"}, 128'(req_ready), 128'(onehot));
    @(posedge clk); #1;
    req_valid = '0;
    if (stale) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      stale_force = 1'b0;
    end
    wait_resp(g, lat);
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_id"}, 128'(resp_id), 128'(idx));
    chk({tag, "_err"}, 128'(resp_err), 128'(exp_err));
    @(negedge clk);
    chk({tag, "_valid_drop"}, 128'(resp_valid), 128'(0));
  endtask

  typedef struct {
    int           idx;
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int g, lat, prev, seen;
    logic [127:0] exp_ct;
    logic [127:0] rr_pt[4];
    logic [127:0] rr_key[4];
    bit           m_busy;
    int           m_ptr, m_grant, m_resp, m_id, gsel;
    logic [127:0] m_ct, m_key;
    logic [NUM_REQ-1:0] exp_ready;
    bit           exp_rv;

    rst = 1'b1; req_valid = '0; req_plaintext = '0; req_key = '0;
    resp_ready = 1'b0; stub_hang = 1'b0; stale_force = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_resp_data", resp_data, 128'(0));
    chk("rst_resp_id", 128'(resp_id), 128'(0));
    chk("rst_resp_err", 128'(resp_err), 128'(0));
    chk("rst_core_rst", 128'(core_rst), 128'(0));
    chk("rst_core_start", 128'(core_start), 128'(0));
    chk("rst_core_pt", core_plaintext, 128'(0));
    chk("rst_core_key", core_key, 128'(0));

    vecs[0] = '{0, FIPS_PT, FIPS_KEY, FIPS_CT};
    vecs[1] = '{1, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'h0};
    vecs[2] = '{2, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff, 128'h0, 128'h0};
    vecs[3] = '{3, 128'h0, 128'hdead_beef_cafe_f00d_0bad_c0de_1234_5678, 128'h0};
    for (int i = 1; i < 4; i++) vecs[i].ct = fake_aes(vecs[i].pt, vecs[i].key);
    for (int i = 0; i < 4; i++) begin
      run_op("vec", vecs[i].idx, vecs[i].pt, vecs[i].key, vecs[i].ct, 1'b0, LAT, 1'b0);
    end

    // Back-pressure: result held for 20 cycles, waiting requester not granted meanwhile.
    @(posedge clk); #1;
    set_req(1, 128'hA1, 128'hB1);
    req_valid = 4'b0010;
    resp_ready = 1'b0;
    wait_grant(g);
    chk("bp_grant", 128'(req_ready), 128'(4'b0010));
    @(posedge clk); #1;
    set_req(0, 128'hC0, 128'hD0);
    req_valid = 4'b0001;
    wait_resp(g, lat);
    chk("bp_latency", 128'(lat), 128'(LAT));
    exp_ct = fake_aes(128'hA1, 128'hB1);
    for (int k = 0; k < 20; k++) begin
      chk("bp_hold_data", resp_data, exp_ct);
      chk("bp_hold_ctl", 128'({resp_valid, resp_err, resp_id, req_ready}), 128'({1'b1, 1'b0, 2'd1, 4'b0000}));
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake", 128'({resp_valid, req_ready}), 128'({1'b1, 4'b0000}));
    @(negedge clk);
    chk("bp_next_grant", 128'({resp_valid, req_ready}), 128'({1'b0, 4'b0001}));
    g = cyc;
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp(g, lat);
    chk("bp2_latency", 128'(lat), 128'(LAT));
    chk("bp2_id", 128'(resp_id), 128'(0));
    chk("bp2_data", resp_data, fake_aes(128'hC0, 128'hD0));

    // Hung core: watchdog abort, then a normal op recovers.
    stub_hang = 1'b1;
    rst_pulses = 0;
    run_op("hang", 2, 128'h77, 128'h88, 128'h0, 1'b1, TIMEOUT + 3, 1'b0);
    chk("hang_core_rst_pulses", 128'(rst_pulses), 128'(1));
    stub_hang = 1'b0;
    run_op("recover", 3, 128'h99, 128'hAA, fake_aes(128'h99, 128'hAA), 1'b0, LAT, 1'b0);

    // Done left high into the first WAIT cycle must not complete the op.
    run_op("stale", 1, 128'h1234, 128'h5678, fake_aes(128'h1234, 128'h5678), 1'b0, LAT, 1'b1);

    // Reset while waiting on the core discards the operation.
    @(posedge clk); #1;
    set_req(0, 128'h42, 128'h43);
    req_valid = 4'b0001;
    wait_grant(g);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1 rst_pulses = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    chk("midrst_no_resp", 128'(seen), 128'(0));
    chk("midrst_no_core_rst", 128'(rst_pulses), 128'(0));

    // All requesters held valid: strict rotation at one op per 14 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rr_pt[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rr_key[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      set_req(i, rr_pt[i], rr_key[i]);
    end
    req_valid = 4'hF;
    resp_ready = 1'b1;
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      oh[k % 4] = 1'b1;
      wait_grant(g);
      chk("rr_grant", 128'(req_ready), 128'(oh));
      if (k > 0) chk("rr_interval", 128'(g - prev), 128'(14));
      prev = g;
      wait_resp(g, lat);
      chk("rr_id", 128'(resp_id), 128'(k % 4));
      chk("rr_data", resp_data, fake_aes(rr_pt[k % 4], rr_key[k % 4]));
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_busy = 1'b0; m_ptr = 0; m_grant = 0; m_resp = 0; m_id = 0; m_ct = '0; m_key = '0;
    for (int t = 0; t < 800; t++) begin
      @(posedge clk); #1;
      req_valid  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        set_req(i, {$urandom(), $urandom(), $urandom(), $urandom()},
                   {$urandom(), $urandom(), $urandom(), $urandom()});
      end
      @(negedge clk);
      exp_ready = '0;
      gsel = -1;
      if (!m_busy) begin
        for (int k = 0; k < 4; k++) begin
          if (gsel < 0 && req_valid[(m_ptr + k) % 4]) gsel = (m_ptr + k) % 4;
        end
        if (gsel >= 0) exp_ready[gsel] = 1'b1;
      end
      exp_rv = m_busy && (cyc >= m_resp);
      chk("rnd_req_ready", 128'(req_ready), 128'(exp_ready));
      chk("rnd_resp_valid", 128'(resp_valid), 128'(exp_rv));
      chk("rnd_core_start", 128'(core_start), 128'(m_busy && (cyc == m_grant + 1)));
      if (m_busy) chk("rnd_core_key", core_key, m_key);
      if (exp_rv) begin
        chk("rnd_resp_data", resp_data, m_ct);
        chk("rnd_resp_id_err", 128'({resp_id, resp_err}), 128'({2'(m_id), 1'b0}));
      end
      if (gsel >= 0) begin
        m_busy  = 1'b1;
        m_grant = cyc;
        m_resp  = cyc + LAT;
        m_ptr   = (gsel + 1) % 4;
        m_id    = gsel;
        m_key   = req_key[gsel*128 +: 128];
        m_ct    = fake_aes(req_plaintext[gsel*128 +: 128], m_key);
      end else if (exp_rv && resp_ready) begin
        m_busy = 1'b0;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
